// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial add/subtract controller.
// State encodings are fixed to 2 bits; the unused code 2'd3 falls back to idle.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Signed overflow: the carry into the MSB disagrees with the carry out of it.
  function automatic logic ovf_calc(input logic c_msb_in, input logic c_out);
    return c_msb_in ^ c_out;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder built from two half adders.
// It is the single shared arithmetic cell of the serial controller.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1_s;
  logic c1_s;
  logic c2_s;

  half_adder u_ha0 (.x(a),    .y(b),   .s(s1_s), .c(c1_s));
  half_adder u_ha1 (.x(s1_s), .y(cin), .s(s),    .c(c2_s));

  assign cout = c1_s | c2_s;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full_adder cell is reused for WIDTH
// cycles, LSB first, with a start/busy/done handshake around the operation.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  // The result register is one bit short: the final bit comes straight from the cell.
  logic [WIDTH-2:0]   r_sh_r;
  logic [WIDTH-1:0]   r_full_s;
  logic               carry_r;
  logic               sub_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               fa_b_s;
  logic               fa_sum_s;
  logic               fa_cout_s;
  logic               last_s;

  assign fa_b_s   = b_sh_r[0] ^ sub_r;
  assign r_full_s = {fa_sum_s, r_sh_r};
  assign last_s   = (cnt_r == CNT_LAST);

  full_adder u_fa (
    .a    (a_sh_r[0]),
    .b    (fa_b_s),
    .cin  (carry_r),
    .s    (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Next-state decode; any unknown encoding recovers to idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, shift/carry/count datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      r_sh_r  <= {(WIDTH-1){1'b0}};
      carry_r <= 1'b0;
      sub_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != ST_IDLE);
      done    <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= sub;
            sub_r   <= sub;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          r_sh_r  <= r_full_s[WIDTH-1:1];
          carry_r <= fa_cout_s;
          if (last_s) begin
            // carry_r still holds the carry into the MSB during the last bit.
            cnt_r <= {CNT_W{1'b0}};
            sum   <= r_full_s;
            cout  <= fa_cout_s;
            ovf   <= ovf_calc(carry_r, fa_cout_s);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
